// File: rtl/water_dispenser_pkg.sv
// rtl/water_dispenser_pkg.sv - shared amount widths, limits and state encoding for the dispenser
package water_dispenser_pkg;

  localparam int AMOUNT_WIDTH   = 14;
  localparam int MAXIMUM_AMOUNT = 9999;

  typedef logic [AMOUNT_WIDTH-1:0] amount_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPENSING,
    ST_DONE,
    ST_FAULT
  } state_t;

  function automatic logic amount_valid(input amount_t amount);
    return (amount != '0) && (amount <= amount_t'(MAXIMUM_AMOUNT));
  endfunction

endpackage

// File: rtl/water_dispense_controller_if.sv
// rtl/water_dispense_controller_if.sv - entry-block side and valve side signals of the dispense stage
interface water_dispense_controller_if;
  import water_dispenser_pkg::*;

  amount_t total_amount;
  logic    button_ok;
  logic    button_cancel;
  logic    flow_pulse;
  logic    valve_open;
  logic    busy;
  amount_t dispensed_amount;
  logic    done;
  logic    fault;
  logic    clear_entry;

  modport master (
    output total_amount, button_ok, button_cancel, flow_pulse,
    input  valve_open, busy, dispensed_amount, done, fault, clear_entry
  );

  modport slave (
    input  total_amount, button_ok, button_cancel, flow_pulse,
    output valve_open, busy, dispensed_amount, done, fault, clear_entry
  );

endinterface

// File: rtl/water_flow_meter.sv
// rtl/water_flow_meter.sv - flow edge detect, pulse-to-millilitre prescaler and stall timeout
module water_flow_meter #(
  parameter int PULSES_PER_ML  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic flow_pulse,
  output logic ml_tick,
  output logic stall
);

  localparam int PW = (PULSES_PER_ML > 1) ? $clog2(PULSES_PER_ML) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSES_PER_ML - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          flow_q;
  logic          flow_edge;
  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] idle_cnt;

  // ml_tick and stall are combinational so the controller acts in the same cycle the edge is sampled
  assign flow_edge = flow_pulse & ~flow_q;
  assign ml_tick   = enable & flow_edge & (pulse_cnt == PULSE_LAST);
  assign stall     = enable & ~flow_edge & (idle_cnt == TIMEOUT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      flow_q    <= 1'b0;
      pulse_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      flow_q <= flow_pulse;
      if (clear) begin
        pulse_cnt <= '0;
        idle_cnt  <= '0;
      end else if (enable) begin
        if (flow_edge) begin
          idle_cnt  <= '0;
          pulse_cnt <= ml_tick ? '0 : pulse_cnt + 1'b1;
        end else if (idle_cnt != TIMEOUT_LAST) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/water_dispense_controller.sv
// rtl/water_dispense_controller.sv - valve FSM, target register and delivered-millilitre counter
module water_dispense_controller
  import water_dispenser_pkg::*;
#(
  parameter int PULSES_PER_ML  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  water_dispense_controller_if.slave bus
);

  state_t  state;
  amount_t target;
  logic    start;
  logic    meter_enable;
  logic    ml_tick;
  logic    stall;
  logic    complete;

  assign meter_enable = (state == ST_DISPENSING);
  assign start        = (state == ST_IDLE) && bus.button_ok && amount_valid(bus.total_amount);
  assign complete     = ml_tick && (amount_t'(bus.dispensed_amount + 1'b1) == target);

  water_flow_meter #(
    .PULSES_PER_ML  (PULSES_PER_ML),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_meter (
    .clock      (clock),
    .reset      (reset),
    .enable     (meter_enable),
    .clear      (start),
    .flow_pulse (bus.flow_pulse),
    .ml_tick    (ml_tick),
    .stall      (stall)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= ST_IDLE;
      target               <= '0;
      bus.valve_open       <= 1'b0;
      bus.busy             <= 1'b0;
      bus.dispensed_amount <= '0;
      bus.done             <= 1'b0;
      bus.fault            <= 1'b0;
      bus.clear_entry      <= 1'b0;
    end else begin
      bus.done        <= 1'b0;
      bus.clear_entry <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state                <= ST_DISPENSING;
            target               <= bus.total_amount;
            bus.dispensed_amount <= '0;
            bus.valve_open       <= 1'b1;
            bus.busy             <= 1'b1;
          end else if (bus.button_cancel) begin
            bus.clear_entry <= 1'b1;
          end
        end
        ST_DISPENSING: begin
          // a millilitre that flowed in a cancel cycle is still counted
          if (ml_tick) begin
            bus.dispensed_amount <= bus.dispensed_amount + 1'b1;
          end
          if (complete) begin
            state           <= ST_DONE;
            bus.valve_open  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.clear_entry <= 1'b1;
          end else if (bus.button_cancel) begin
            state           <= ST_IDLE;
            bus.valve_open  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.clear_entry <= 1'b1;
          end else if (stall) begin
            state          <= ST_FAULT;
            bus.valve_open <= 1'b0;
            bus.busy       <= 1'b0;
            bus.fault      <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_FAULT: begin
          if (bus.button_cancel) begin
            state           <= ST_IDLE;
            bus.fault       <= 1'b0;
            bus.clear_entry <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_water_dispense_controller.sv
// tb/tb_water_dispense_controller.sv - vector table, directed sequences and random run against a reference model
module tb_water_dispense_controller;

  localparam int PPM = 4;
  localparam int TMO = 100;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAULT = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  water_dispense_controller_if bus ();

  water_dispense_controller #(
    .PULSES_PER_ML  (PPM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [13:0] amount;
    logic        ok;
    logic        cancel;
    logic        exp_valve;
    logic        exp_clear;
  } vec_t;

  vec_t vecs[7];

  int m_mode, m_target, m_edges, m_since, m_disp;
  bit m_prev, m_clr;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_flow();
    bus.flow_pulse = 1'b1;
    cyc();
    bus.flow_pulse = 1'b0;
    cyc();
  endtask

  task automatic start_run(input int amount);
    bus.total_amount = 14'(amount);
    bus.button_ok    = 1'b1;
    cyc();
    bus.button_ok    = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_target = 0; m_edges = 0; m_since = 0; m_disp = 0;
    m_prev = 1'b0; m_clr = 1'b0;
  endtask

  // delivered volume is simply total run edges divided by pulses per millilitre
  task automatic model_step(input int amt, input bit ok, input bit cancel, input bit flow);
    bit edge_seen;
    edge_seen = flow && !m_prev;
    m_clr = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (ok && amt >= 1 && amt <= 9999) begin
          m_mode = M_RUN; m_target = amt; m_edges = 0; m_since = 0; m_disp = 0;
        end else if (cancel) begin
          m_clr = 1'b1;
        end
      end
      M_RUN: begin
        if (edge_seen) begin
          m_edges++;
          m_since = 0;
        end else begin
          m_since++;
        end
        m_disp = m_edges / PPM;
        if (edge_seen && m_disp == m_target) begin
          m_mode = M_DONE; m_clr = 1'b1;
        end else if (cancel) begin
          m_mode = M_IDLE; m_clr = 1'b1;
        end else if (m_since >= TMO) begin
          m_mode = M_FAULT;
        end
      end
      M_DONE: m_mode = M_IDLE;
      default: begin
        if (cancel) begin
          m_mode = M_IDLE; m_clr = 1'b1;
        end
      end
    endcase
    m_prev = flow;
  endtask

  function automatic int dut_vec();
    return int'({bus.valve_open, bus.busy, bus.done, bus.fault, bus.clear_entry, bus.dispensed_amount});
  endfunction

  function automatic int model_vec();
    int v;
    v = m_disp;
    v |= int'(m_clr) << 14;
    v |= int'(m_mode == M_FAULT) << 15;
    v |= int'(m_mode == M_DONE) << 16;
    v |= int'(m_mode == M_RUN) << 17;
    v |= int'(m_mode == M_RUN) << 18;
    return v;
  endfunction

  initial begin
    bus.total_amount  = '0;
    bus.button_ok     = 1'b0;
    bus.button_cancel = 1'b0;
    bus.flow_pulse    = 1'b0;

    vecs[0] = '{14'd0,     1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{14'd10000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{14'd16383, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{14'd0,     1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{14'd9999,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{14'd1,     1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{14'd2,     1'b1, 1'b1, 1'b1, 1'b0};

    cyc();
    cyc();
    check("reset_outputs", dut_vec(), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus.total_amount  = vecs[i].amount;
      bus.button_ok     = vecs[i].ok;
      bus.button_cancel = vecs[i].cancel;
      cyc();
      bus.button_ok     = 1'b0;
      bus.button_cancel = 1'b0;
      check($sformatf("vec%0d_valve", i), int'(bus.valve_open), int'(vecs[i].exp_valve));
      check($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].exp_valve));
      check($sformatf("vec%0d_clear", i), int'(bus.clear_entry), int'(vecs[i].exp_clear));
      if (vecs[i].exp_valve) begin
        bus.button_cancel = 1'b1;
        cyc();
        bus.button_cancel = 1'b0;
      end
      cyc();
    end

    // normal run: 3 mL from 12 edges spaced 10 cycles apart
    start_run(3);
    check("normal_accept_valve", int'(bus.valve_open), 1);
    for (int i = 0; i < 12; i++) begin
      bus.flow_pulse = 1'b1;
      cyc();
      if (i == 3) check("normal_ml1", int'(bus.dispensed_amount), 1);
      if (i < 11) begin
        check($sformatf("normal_valve_e%0d", i), int'(bus.valve_open), 1);
      end else begin
        check("normal_final", dut_vec(), int'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'd3}));
      end
      bus.flow_pulse = 1'b0;
      cyc();
      if (i == 11) check("normal_after_done", dut_vec(), 3);
      repeat (8) cyc();
    end

    start_run(0);
    check("reject_zero", dut_vec(), 3);
    cyc();
    check("reject_zero_hold", dut_vec(), 3);

    start_run(5);
    repeat (9) pulse_flow();
    check("cancel_mid_ml", int'(bus.dispensed_amount), 2);
    bus.button_cancel = 1'b1;
    cyc();
    bus.button_cancel = 1'b0;
    check("cancel_outputs", dut_vec(), int'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'd2}));
    cyc();
    check("cancel_clear_pulse", int'(bus.clear_entry), 0);

    // stall: fault exactly TMO cycles after the third edge
    start_run(2);
    repeat (2) pulse_flow();
    bus.flow_pulse = 1'b1;
    cyc();
    bus.flow_pulse = 1'b0;
    repeat (TMO - 1) cyc();
    check("stall_not_yet", int'({bus.fault, bus.valve_open}), 1);
    cyc();
    check("stall_fault", dut_vec(), int'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0}));
    start_run(2);
    check("stall_ok_ignored", int'({bus.fault, bus.valve_open}), 2);
    bus.button_cancel = 1'b1;
    cyc();
    bus.button_cancel = 1'b0;
    check("stall_cleared", int'({bus.fault, bus.clear_entry}), 1);
    cyc();

    // completion beats cancel in the same cycle
    start_run(1);
    repeat (3) pulse_flow();
    bus.flow_pulse    = 1'b1;
    bus.button_cancel = 1'b1;
    cyc();
    bus.flow_pulse    = 1'b0;
    bus.button_cancel = 1'b0;
    check("simul_done", dut_vec(), int'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'd1}));
    cyc();
    check("simul_idle", int'(bus.done), 0);

    start_run(4);
    repeat (6) pulse_flow();
    check("reset_mid_valve", int'(bus.valve_open), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset_mid_outputs", dut_vec(), 0);
    start_run(1);
    repeat (3) pulse_flow();
    check("after_reset_not_done", int'(bus.done), 0);
    bus.flow_pulse = 1'b1;
    cyc();
    bus.flow_pulse = 1'b0;
    check("after_reset_done", int'({bus.done, bus.dispensed_amount}), int'({1'b1, 14'd1}));
    cyc();

    // random traffic against the reference model
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_reset();
    begin
      int rate;
      int r;
      rate = 50;
      for (int n = 0; n < 3000; n++) begin
        if (n % 150 == 0) rate = ($urandom_range(0, 2) == 0) ? 0 : 50;
        r = int'($urandom_range(0, 9));
        bus.total_amount  = (r < 8) ? 14'(r % 5) : ((r == 8) ? 14'd9990 : 14'd10000);
        bus.button_ok     = ($urandom_range(0, 99) < 3);
        bus.button_cancel = ($urandom_range(0, 99) < 1);
        bus.flow_pulse    = ($urandom_range(0, 99) < rate);
        cyc();
        model_step(int'(bus.total_amount), bus.button_ok, bus.button_cancel, bus.flow_pulse);
        check($sformatf("random_c%0d", n), dut_vec(), model_vec());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/water_dispense_controller.md
# water_dispense_controller

Dispense stage directly downstream of the keypad digit-entry block. It consumes the entered millilitre amount, or target, and the OK/cancel button pulses. It drives the valve, counts millilitres from a flow-sensor pulse train, and detects a stalled flow. When a dispense completes or is cancelled, it tells the entry block to clear.

## Interface
- AMOUNT_WIDTH, 14: width of amount buses; covers 0..9999.
- MAXIMUM_AMOUNT, 9999: largest target accepted, in mL.
- PULSES_PER_ML, 4: flow-sensor rising edges per millilitre; must be ≥1.
- TIMEOUT_CYCLES, 1000000: maximum clock cycles between flow edges while the valve is open.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- total_amount  in  AMOUNT_WIDTH  target from the entry block, sampled only on an accepted start.
- button_ok  in  1  start request, one-cycle pulse.
- button_cancel  in  1  cancel / fault acknowledge, one-cycle pulse.
- flow_pulse  in  1  flow-sensor level, already synchronised to clock.
- valve_open  out  1  valve drive, registered.
- busy  out  1  high in DISPENSING.
- dispensed_amount  out  AMOUNT_WIDTH  millilitres delivered in the current or last run.
- done  out  1  one-cycle pulse on completion.
- fault  out  1  high in FAULT.
- clear_entry  out  1  one-cycle pulse telling the entry block to zero itself.

## Operation
- States: IDLE, DISPENSING, DONE, FAULT.
- Reset: state IDLE, valve_open 0, busy 0, dispensed_amount 0, done 0, fault 0, clear_entry 0, all internal counters 0.
- IDLE:
  - button_ok with 1 ≤ total_amount ≤ MAXIMUM_AMOUNT: latch target, clear dispensed_amount, pulse counter and timeout counter; go to DISPENSING.
  - button_ok with total_amount 0 or above MAXIMUM_AMOUNT: ignored; no state change.
  - button_cancel: one clear_entry pulse; stay in IDLE.
- DISPENSING:
  - Rising edge of flow_pulse (previous-sample register): increment pulse counter and clear the timeout counter.
  - When the pulse counter reaches PULSES_PER_ML it wraps to 0 and dispensed_amount increments.
  - When dispensed_amount would reach target: go to DONE.
  - button_cancel: go to IDLE, pulse clear_entry, hold dispensed_amount.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no flow edge: go to FAULT.
  - button_ok: ignored. total_amount changes after acceptance have no effect.
- DONE: lasts exactly one cycle; done=1 and clear_entry=1; then IDLE.
- FAULT:
  - valve closed, fault=1, dispensed_amount held.
  - button_ok ignored.
  - button_cancel: go to IDLE, fault drops, clear_entry pulses.
- Simultaneous events in DISPENSING; priority is completion > cancel > timeout:
  - Final millilitre and cancel in the same cycle: go to DONE, since that water is already out.
  - Cancel and timeout in the same cycle: go to IDLE, no fault.
  - Flow edge in the timeout cycle: edge wins; counter clears, no fault.
- Flow edges outside DISPENSING: ignored, but the edge-detect register still tracks the input.
- dispensed_amount is never above target and never wraps; it stays until the next accepted start.

## Timing
- Start accepted at edge k: valve_open=1, busy=1 after edge k.
- Completing flow edge sampled at edge m:
  - dispensed_amount = target after edge m.
  - valve_open=0, busy=0, done=1 after edge m.
  - done=0 after edge m+1.
- Cancel at edge c: valve_open=0 after edge c.
- Timeout: FAULT is entered TIMEOUT_CYCLES cycles after the last flow edge, or after start if no edge has arrived.
- reset asserted mid-dispense: valve closes on the next edge; no done or clear_entry pulse.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package water_dispenser_pkg holds:
  - the state encoding;
  - AMOUNT_WIDTH and MAXIMUM_AMOUNT, also used by the entry block.
- Sub-module water_flow_meter contains:
  - edge detect on flow_pulse;
  - the pulse prescaler, emitting one-cycle ml_tick;
  - the timeout counter, emitting stall;
  - a clear input, driven on start.
- Top level: FSM, target register, dispensed_amount counter.

## Test plan
Bench settings: PULSES_PER_ML=4, TIMEOUT_CYCLES=100.
- Normal run: total_amount=3, button_ok, then 12 flow edges spaced 10 cycles apart.
  - valve_open rises on the accept edge and falls on the 12th edge.
  - dispensed_amount=3, with one done and one clear_entry pulse.
- Rejected start: total_amount=0, button_ok.
  - Stays in IDLE; valve_open stays 0; no outputs change.
- Cancel: target 5, 9 flow edges, then button_cancel.
  - IDLE, valve_open=0, dispensed_amount=2, clear_entry pulses, done stays 0.
- Stall: target 2, 3 flow edges, then no edges.
  - fault=1 and valve_open=0 exactly 100 cycles after the 3rd edge.
  - button_ok ignored; button_cancel clears fault.
- Simultaneous final edge and cancel: target 1, 4th edge in the same cycle as button_cancel.
  - DONE, done=1, dispensed_amount=1.
- Reset mid-dispense: target 4, 6 flow edges, then reset for 1 cycle.
  - All outputs 0 after that edge; a following run of target 1 completes after 4 edges.
